// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared types and helpers for the multi-cycle multiply/divide unit.
//   op_e    : MCycleOp encodings (signed/unsigned multiply and divide)
//   state_e : control FSM states
//   Helpers : operation decode, two's-complement negation, conditional negation
//             (used both for operand magnitudes and for the final sign fix).
// Helpers work on MAX_W-bit values; callers zero-extend and size-cast, so the
// unit supports WIDTH up to MAX_W/2.
package mcycle_pkg;

  typedef enum logic [1:0] {
    OP_SMUL = 2'b00,
    OP_UMUL = 2'b01,
    OP_SDIV = 2'b10,
    OP_UDIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int unsigned MAX_W = 128;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_SMUL) || (op == OP_SDIV);
  endfunction

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return (~v) + MAX_W'(1);
  endfunction

  // Magnitude of a negative operand and the sign fix of a result are the same
  // operation: negate when the flag is set.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
    return neg ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/mcycle_muldiv_step.sv
// mcycle_step: combinational single radix-2 iteration on magnitudes.
//   acc_i/acc_o   : accumulator (product high half / partial remainder)
//   sreg_i/sreg_o : shift register (multiplier -> product low half /
//                   dividend -> quotient)
//   opnd_i        : multiplicand or divisor magnitude
//   op_i          : operation; selects add-shift or restoring trial-subtract
module mcycle_step
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] sreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] sreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           take;

  always_comb begin
    // Multiply: conditionally add, then shift {carry, acc, sreg} right by one.
    sum    = {1'b0, acc_i} + (sreg_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: shift next dividend bit into the remainder and trial-subtract.
    rem_sh = {acc_i, sreg_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    take   = (rem_sh >= {1'b0, opnd_i});

    if (is_div_op(op_i)) begin
      acc_o  = take ? WIDTH'(diff) : rem_sh[WIDTH-1:0];
      sreg_o = {sreg_i[WIDTH-2:0], take};
    end else begin
      acc_o  = sum[WIDTH:1];
      sreg_o = {sum[0], sreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_muldiv.sv
// mcycle_muldiv: multi-cycle signed/unsigned multiply and divide unit.
//   CLK, RESETn (async, active low)
//   Start      : request, accepted in IDLE or DONE
//   MCycleOp   : 00 smul, 01 umul, 10 sdiv, 11 udiv
//   Operand1/2 : multiplicand/dividend, multiplier/divisor
//   Result1/2  : product low/high or quotient/remainder, held until next Done
//   Busy       : computing; Done: one-cycle result pulse
//   DivByZero  : divide had Operand2 == 0; cleared by the next accepted Start
// Optional macro MCYCLE_EARLY_OUT_EN: divide by zero or multiply by zero skips
// COMPUTE and finishes one cycle after Start with identical results.
// WIDTH must be in 4..64.
module mcycle_muldiv
  import mcycle_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] raw1_q, raw1_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             divz_q, divz_d;
  logic             dbz_q, dbz_d;

  op_e              op_in;
  logic             accept;
  logic             last_step;
  logic             early_out;
  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] acc_n, sreg_n;
  logic [PW-1:0]    prod;

  assign op_in = op_e'(MCycleOp);

  mcycle_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .sreg_i(sreg_q),
    .opnd_i(opnd_q),
    .op_i  (op_q),
    .acc_o (acc_n),
    .sreg_o(sreg_n)
  );

  always_comb begin
    accept    = Start && ((state_q == IDLE) || (state_q == DONE));
    last_step = (state_q == COMPUTE) && (cnt_q == CNT_W'(WIDTH - 1));
  end

`ifdef MCYCLE_EARLY_OUT_EN
  always_comb begin
    early_out = is_div_op(op_in) ? (Operand2 == '0)
                                 : ((Operand1 == '0) || (Operand2 == '0));
  end
`else
  always_comb begin
    early_out = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = early_out ? DONE : COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (state_q == COMPUTE);
    Done = (state_q == DONE);
  end

  assign Result1   = result1_q;
  assign Result2   = result2_q;
  assign DivByZero = dbz_q;

  // Datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    opnd_d    = opnd_q;
    raw1_d    = raw1_q;
    result1_d = result1_q;
    result2_d = result2_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    dbz_d     = dbz_q;
    sign1     = 1'b0;
    sign2     = 1'b0;
    mag1      = '0;
    mag2      = '0;
    prod      = '0;

    if (accept) begin
      sign1     = is_signed_op(op_in) & Operand1[WIDTH-1];
      sign2     = is_signed_op(op_in) & Operand2[WIDTH-1];
      mag1      = WIDTH'(cond_neg(MAX_W'(Operand1), sign1));
      mag2      = WIDTH'(cond_neg(MAX_W'(Operand2), sign2));
      op_d      = op_in;
      cnt_d     = '0;
      acc_d     = '0;
      raw1_d    = Operand1;
      divz_d    = (Operand2 == '0);
      neg_res_d = sign1 ^ sign2;
      neg_rem_d = sign1;
      dbz_d     = 1'b0;
      if (is_div_op(op_in)) begin
        sreg_d = mag1;
        opnd_d = mag2;
      end else begin
        sreg_d = mag2;
        opnd_d = mag1;
      end
      if (early_out) begin
        if (is_div_op(op_in)) begin
          result1_d = '1;
          result2_d = Operand1;
          dbz_d     = 1'b1;
        end else begin
          result1_d = '0;
          result2_d = '0;
        end
      end
    end else if (state_q == COMPUTE) begin
      acc_d  = acc_n;
      sreg_d = sreg_n;
      cnt_d  = cnt_q + CNT_W'(1);
      // Final step: results come straight from the step outputs so the sign
      // fix lands in the same cycle as the last iteration.
      if (last_step) begin
        if (is_div_op(op_q)) begin
          if (divz_q) begin
            result1_d = '1;
            result2_d = raw1_q;
            dbz_d     = 1'b1;
          end else begin
            result1_d = WIDTH'(cond_neg(MAX_W'(sreg_n), neg_res_q));
            result2_d = WIDTH'(cond_neg(MAX_W'(acc_n), neg_rem_q));
          end
        end else begin
          prod      = PW'(cond_neg(MAX_W'({acc_n, sreg_n}), neg_res_q));
          result1_d = prod[WIDTH-1:0];
          result2_d = prod[PW-1:WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q     <= '0;
      op_q      <= OP_SMUL;
      acc_q     <= '0;
      sreg_q    <= '0;
      opnd_q    <= '0;
      raw1_q    <= '0;
      result1_q <= '0;
      result2_q <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      sreg_q    <= sreg_d;
      opnd_q    <= opnd_d;
      raw1_q    <= raw1_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Self-checking bench for mcycle_muldiv (WIDTH=32): directed literal cases,
// a transaction-level reference model compared every cycle, random traffic.
module tb_mcycle_muldiv;

  localparam int W = 32;

`ifdef MCYCLE_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        dz;
  } res_t;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done, DivByZero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  mcycle_muldiv #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero)
  );

  // Reference arithmetic with 64-bit integers
  function automatic res_t ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, q, m;
    longint unsigned up;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    r  = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); r.r1 = p[31:0]; r.r2 = p[63:32]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; p = up; r.r1 = p[31:0]; r.r2 = p[63:32]; end
      2'b10: begin
        if (b == 32'd0) begin r.r1 = 32'hFFFFFFFF; r.r2 = a; r.dz = 1'b1; end
        else begin q = sa / sb; m = sa % sb; p = 64'(q); r.r1 = p[31:0]; p = 64'(m); r.r2 = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin r.r1 = 32'hFFFFFFFF; r.r2 = a; r.dz = 1'b1; end
        else begin r.r1 = a / b; r.r2 = a % b; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_early(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MCYCLE_EARLY_OUT_EN
    return op[1] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0));
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: phase 0 idle, 1 busy, 2 done
  int          m_phase, m_left;
  logic [31:0] m_r1, m_r2;
  logic        m_dz;
  res_t        m_pend, m_now;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_phase <= 0; m_left <= 0; m_r1 <= '0; m_r2 <= '0; m_dz <= 1'b0; m_pend <= '0;
    end else if (m_phase == 1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_phase <= 2; m_r1 <= m_pend.r1; m_r2 <= m_pend.r2; m_dz <= m_pend.dz;
      end
    end else if (Start) begin
      m_now = ref_op(MCycleOp, Operand1, Operand2);
      if (is_early(MCycleOp, Operand1, Operand2)) begin
        m_phase <= 2; m_r1 <= m_now.r1; m_r2 <= m_now.r2; m_dz <= m_now.dz;
      end else begin
        m_phase <= 1; m_left <= W; m_pend <= m_now; m_dz <= 1'b0;
      end
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      checks++;
      if ({Busy, Done, DivByZero, Result1, Result2} !==
          {(m_phase == 1), (m_phase == 2), m_dz, m_r1, m_r2}) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got busy=%b done=%b dbz=%b r1=%h r2=%h, expected busy=%b done=%b dbz=%b r1=%h r2=%h",
                 $time, Busy, Done, DivByZero, Result1, Result2,
                 (m_phase == 1), (m_phase == 2), m_dz, m_r1, m_r2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // mode 0: leave inputs; 1: random junk on inputs while busy; 2: drop Start after first cycle
  task automatic wait_done(input int mode, output int n, output int bn);
    n  = 0;
    bn = 0;
    do begin
      @(negedge CLK);
      n++;
      if (Busy) bn++;
      if (mode == 2 && n == 1) Start = 1'b0;
      if (mode == 1 && !Done) begin
        Start    = (n < 20) ? 1'($urandom % 2) : 1'b0;
        MCycleOp = 2'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
    end while (!Done && n < 100);
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done after %0d cycles, expected Done", n);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bn);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    wait_done(1, lat, bn);
    Start = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 RESETn = 1'b0;
    #1;
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_dbz"}, 32'(DivByZero), 32'd0);
    check({tag, "_r1"}, Result1, 32'd0);
    check({tag, "_r2"}, Result2, 32'd0);
  endtask

  int lat, bn, n1, n2;

  initial begin
    RESETn = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    #1;
    async_reset_check("reset");
    chk_en = 1'b1;
    @(negedge CLK); @(negedge CLK);
    #2 RESETn = 1'b1;

    do_op(2'b01, 32'd6, 32'd3, lat, bn);
    check("umul_lat", 32'(lat), 32'd33);
    check("umul_busy_cycles", 32'(bn), 32'd32);
    check("umul_r1", Result1, 32'd18);
    check("umul_r2", Result2, 32'd0);

    do_op(2'b00, 32'hFCDEFFFF, 32'hFAFFFFFF, lat, bn);
    check("smul_r1", Result1, 32'h08210001);
    check("smul_r2", Result2, 32'h000FA500);

    do_op(2'b10, 32'hFCDEFFFD, 32'd2, lat, bn);
    check("sdiv_q", Result1, 32'hFE6F7FFF);
    check("sdiv_r", Result2, 32'hFFFFFFFF);
    check("sdiv_dbz", 32'(DivByZero), 32'd0);

    do_op(2'b11, 32'd100, 32'd7, lat, bn);
    check("udiv_q", Result1, 32'd14);
    check("udiv_r", Result2, 32'd2);

    do_op(2'b10, 32'h12345678, 32'd0, lat, bn);
    check("div0_lat", 32'(lat), 32'(ZLAT));
    check("div0_q", Result1, 32'hFFFFFFFF);
    check("div0_r", Result2, 32'h12345678);
    check("div0_dbz", 32'(DivByZero), 32'd1);

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    check("ovf_q", Result1, 32'h80000000);
    check("ovf_r", Result2, 32'd0);
    check("ovf_dbz", 32'(DivByZero), 32'd0);

    do_op(2'b01, 32'd0, 32'd5, lat, bn);
    check("mul0_lat", 32'(lat), 32'(ZLAT));
    check("mul0_r1", Result1, 32'd0);

    // Start held high across two ops; second captured in the DONE cycle
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd7; Operand2 = 32'd9;
    @(negedge CLK);
    MCycleOp = 2'b10; Operand1 = 32'hFFFFFF9C; Operand2 = 32'd7;
    wait_done(0, n1, bn);
    check("b2b_lat1", 32'(n1 + 1), 32'd33);
    check("b2b_r1_first", Result1, 32'd63);
    wait_done(2, n2, bn);
    check("b2b_lat2", 32'(n2), 32'd33);
    check("b2b_q", Result1, 32'hFFFFFFF2);
    check("b2b_r", Result2, 32'hFFFFFFFE);
    Start = 1'b0;

    // Reset in the middle of COMPUTE
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd5; Operand2 = 32'd5;
    @(negedge CLK);
    Start = 1'b0;
    repeat (5) @(negedge CLK);
    async_reset_check("midreset");
    @(negedge CLK);
    #2 RESETn = 1'b1;
    do_op(2'b01, 32'd6, 32'd3, lat, bn);
    check("post_reset_lat", 32'(lat), 32'd33);
    check("post_reset_r1", Result1, 32'd18);

    // Random traffic, checked cycle by cycle against the model
    repeat (3000) begin
      @(negedge CLK);
      Start    = ($urandom % 4 == 0);
      MCycleOp = 2'($urandom);
      Operand1 = pick_val();
      Operand2 = pick_val();
    end
    Start = 1'b0;
    repeat (40) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
